hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath, placed beside the forwarding logic in ID/EX. It generates the stall, bubble and flush controls for the PC, IF/ID and ID/EX registers. It covers three cases: load-use hazards that forwarding cannot resolve, taken-branch flushes, and a multi-cycle multiplier that occupies EX for several cycles. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_controller.sv | 124 ++++++++++++
 tb/tb_hazard_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hc_state_t;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 8;
  localparam int CNT_W_DEF   = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/bubble/flush sequencing for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and multi-cycle multiply holds, plus perf counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       rs_IF_ID,
  input  logic [4:0]       rt_IF_ID,
  input  logic             UsesRt_IF_ID,
  input  logic [4:0]       rt_ID_EX,
  input  logic             MemRead_ID_EX,
  input  logic             MulStart_ID_EX,
  input  logic             BranchTaken,
  input  logic             CntClear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_Hold,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT = (MUL_LATENCY < MUL_LAT_MIN) ? MUL_LAT_MIN :
                       (MUL_LATENCY > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LATENCY;
  localparam bit       MUL_MULTI = (LAT > 1);
  localparam logic [2:0] MCNT_INIT = MUL_MULTI ? 3'(LAT - 2) : 3'd0;

  hc_state_t  state_q, state_d;
  logic [2:0] mcnt_q, mcnt_d;

  logic lu, ms, h_busy, br;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold;

  assign lu = MemRead_ID_EX && (rt_ID_EX != REG_ZERO) &&
              ((rt_ID_EX == rs_IF_ID) || (UsesRt_IF_ID && (rt_ID_EX == rt_IF_ID)));
  assign ms     = (state_q == RUN) && MulStart_ID_EX && MUL_MULTI;
  assign h_busy = (state_q == MUL_BUSY) && (mcnt_q != 3'd0);
  assign br     = BranchTaken && (state_q == RUN) && !ms;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      mcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      RUN: begin
        if (ms) begin
          state_d = MUL_BUSY;
          mcnt_d  = MCNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (mcnt_q != 3'd0) mcnt_d = mcnt_q - 3'd1;
        else                state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output priority: branch flush, multiply hold, load-use stall, normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (Reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (br) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ms || h_busy) begin
      ex_hold      = 1'b1;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign PCWrite      = pc_write;
  assign IF_ID_Write  = if_id_write;
  assign IF_ID_Flush  = if_id_flush;
  assign ID_EX_Bubble = id_ex_bubble;
  assign EX_Hold      = ex_hold;
  assign MulBusy      = (state_q == MUL_BUSY) && !Reset;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (Clk),
    .rst (Reset),
    .inc (!pc_write),
    .clr (CntClear),
    .cnt (StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (Clk),
    .rst (Reset),
    .inc (if_id_flush),
    .clr (CntClear),
    .cnt (FlushCount)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MUL_LATENCY=4, CNT_W=4).
module tb_hazard_controller;

  localparam int CW = 4;

  logic          Clk;
  logic          Reset;
  logic [4:0]    rs_IF_ID, rt_IF_ID, rt_ID_EX;
  logic          UsesRt_IF_ID, MemRead_ID_EX, MulStart_ID_EX, BranchTaken, CntClear;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy;
  logic [CW-1:0] StallCycles, FlushCount;

  int checks = 0;
  int errors = 0;

  hazard_controller #(.MUL_LATENCY(4), .CNT_W(CW)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .rs_IF_ID       (rs_IF_ID),
    .rt_IF_ID       (rt_IF_ID),
    .UsesRt_IF_ID   (UsesRt_IF_ID),
    .rt_ID_EX       (rt_ID_EX),
    .MemRead_ID_EX  (MemRead_ID_EX),
    .MulStart_ID_EX (MulStart_ID_EX),
    .BranchTaken    (BranchTaken),
    .CntClear       (CntClear),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .EX_Hold        (EX_Hold),
    .MulBusy        (MulBusy),
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // packs {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy}
  function automatic logic [31:0] ctl();
    return {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, MulBusy};
  endfunction

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lu_set(input logic en);
    MemRead_ID_EX = en;
    rt_ID_EX      = 5'd8;
    rs_IF_ID      = 5'd8;
  endtask

  initial begin
    Reset = 1'b0; rs_IF_ID = 5'd0; rt_IF_ID = 5'd0; rt_ID_EX = 5'd0;
    UsesRt_IF_ID = 1'b0; MemRead_ID_EX = 1'b0; MulStart_ID_EX = 1'b0;
    BranchTaken = 1'b0; CntClear = 1'b0;
    #1 Reset = 1'b1;
    #2;
    chk("reset_ctl", ctl(), 32'b001100);
    chk("reset_stall", StallCycles, 0);
    chk("reset_flush", FlushCount, 0);

    step(); Reset = 1'b0; settle();
    chk("idle_ctl", ctl(), 32'b110000);

    // load-use: lw r8 followed by consumer of r8
    step(); lu_set(1'b1); settle();
    chk("lu_ctl", ctl(), 32'b000100);
    chk("lu_stall_before", StallCycles, 0);
    step(); MemRead_ID_EX = 1'b0; settle();
    chk("lu_release_ctl", ctl(), 32'b110000);
    chk("lu_stall_after", StallCycles, 1);

    // destination r0 never stalls
    step(); MemRead_ID_EX = 1'b1; rt_ID_EX = 5'd0; rs_IF_ID = 5'd0; settle();
    chk("r0_no_stall", ctl(), 32'b110000);
    // rt match without rt use
    step(); rt_ID_EX = 5'd9; rt_IF_ID = 5'd9; rs_IF_ID = 5'd3; UsesRt_IF_ID = 1'b0; settle();
    chk("rt_unused_no_stall", ctl(), 32'b110000);
    step(); UsesRt_IF_ID = 1'b1; settle();
    chk("rt_used_stall", ctl(), 32'b000100);
    step(); MemRead_ID_EX = 1'b0; UsesRt_IF_ID = 1'b0; settle();
    chk("stall_cnt_2", StallCycles, 2);

    // branch taken overrides a simultaneous load-use
    step(); lu_set(1'b1); BranchTaken = 1'b1; settle();
    chk("br_over_lu_ctl", ctl(), 32'b111100);
    step(); lu_set(1'b0); BranchTaken = 1'b0; settle();
    chk("br_flush_cnt", FlushCount, 1);
    chk("br_stall_unchanged", StallCycles, 2);
    chk("br_release_ctl", ctl(), 32'b110000);

    // clear counters, then a 4-cycle multiply with load-use present early on
    step(); CntClear = 1'b1; settle();
    step(); CntClear = 1'b0; settle();
    chk("clear_stall", StallCycles, 0);
    chk("clear_flush", FlushCount, 0);
    step(); MulStart_ID_EX = 1'b1; lu_set(1'b1); settle();
    chk("mul_c1", ctl(), 32'b000010);
    step(); BranchTaken = 1'b1; settle();
    chk("mul_c2_branch_ignored", ctl(), 32'b000011);
    step(); BranchTaken = 1'b0; settle();
    chk("mul_c3", ctl(), 32'b000011);
    step(); lu_set(1'b0); settle();
    chk("mul_c4", ctl(), 32'b110001);
    chk("mul_stall_3", StallCycles, 3);
    step(); MulStart_ID_EX = 1'b0; settle();
    chk("mul_c5_run", ctl(), 32'b110000);
    chk("mul_stall_final", StallCycles, 3);
    chk("mul_flush_0", FlushCount, 0);

    // reset asserted in the second MUL_BUSY cycle
    step(); MulStart_ID_EX = 1'b1; settle();
    chk("rmul_c1", ctl(), 32'b000010);
    step(); settle();
    chk("rmul_c2", ctl(), 32'b000011);
    step(); Reset = 1'b1; settle();
    chk("rmul_reset_ctl", ctl(), 32'b001100);
    chk("rmul_reset_stall", StallCycles, 0);
    step(); Reset = 1'b0; settle();
    chk("rmul_new_c1", ctl(), 32'b000010);
    step(); settle();
    chk("rmul_new_c2", ctl(), 32'b000011);
    step(); settle();
    chk("rmul_new_c3", ctl(), 32'b000011);
    step(); settle();
    chk("rmul_new_c4", ctl(), 32'b110001);
    chk("rmul_new_stall", StallCycles, 3);
    step(); MulStart_ID_EX = 1'b0; settle();

    // saturation: 20 load-use stall cycles from 3 pins at 15
    step(); lu_set(1'b1); settle();
    for (int i = 0; i < 19; i++) begin
      step(); settle();
    end
    step(); settle();
    chk("sat_stall_15", StallCycles, 15);
    step(); CntClear = 1'b1; settle();
    chk("clear_with_stall_ctl", ctl(), 32'b000100);
    step(); CntClear = 1'b0; lu_set(1'b0); settle();
    chk("clear_over_inc", StallCycles, 0);
    step(); settle();
    chk("clear_hold_zero", StallCycles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
